// File: rtl/i2c_xact_sequencer.sv
// Two-requester I2C transaction sequencer driving a byte-level master core through
// START, address, data and STOP commands, with round-robin arbitration and a per-command timeout.
//   state | meaning
//   IDLE  | waiting for a request
//   START | START command outstanding
//   ADDR  | address byte WRITE outstanding
//   DATA  | data byte WRITE or READ outstanding
//   STOP  | STOP command outstanding
//   DONE  | one-cycle completion pulse to the owner
module i2c_xact_sequencer #(
   parameter int MAX_LEN        = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [1:0]  req_valid_i,
   input  logic [13:0] req_addr_i,
   input  logic [1:0]  req_rw_i,
   input  logic [7:0]  req_len_i,
   output logic [1:0]  req_ready_o,
   input  logic [15:0] wr_data_i,
   output logic [1:0]  wr_pop_o,
   output logic [7:0]  rd_data_o,
   output logic [1:0]  rd_valid_o,
   output logic [1:0]  done_o,
   output logic        err_o,
   output logic        cmd_valid_o,
   output logic [2:0]  cmd_o,
   output logic [7:0]  cmd_data_o,
   input  logic        cmd_done_i,
   input  logic        cmd_nak_i,
   input  logic [7:0]  cmd_rdata_i
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_STOP  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam logic [2:0] C_READ_ACK = 3'b000;
   localparam logic [2:0] C_READ_NAK = 3'b001;
   localparam logic [2:0] C_START    = 3'b010;
   localparam logic [2:0] C_STOP     = 3'b011;
   localparam logic [2:0] C_WRITE    = 3'b100;

   logic [2:0]    r_state, r_nxt;
   logic          r_gap, r_owner, r_ptr, r_rw, r_err;
   logic [6:0]    r_addr;
   logic [3:0]    r_len, r_cnt;
   logic [TW-1:0] r_tmo;
   logic [1:0]    r_ready, r_pop, r_rd_valid, r_done;
   logic [7:0]    r_rd_data, r_cmd_data;
   logic          r_err_o, r_cmd_valid;
   logic [2:0]    r_cmd;

   logic          w_win;
   logic [3:0]    w_len_sel, w_len;
   logic [7:0]    w_wdata;
   logic [1:0]    w_onehot;
   logic          w_last;

   always_comb begin
      w_win     = (req_valid_i == 2'b11) ? r_ptr : req_valid_i[1];
      w_len_sel = w_win ? req_len_i[7:4] : req_len_i[3:0];
      w_len     = (w_len_sel > 4'(MAX_LEN)) ? 4'(MAX_LEN) : w_len_sel;
      w_wdata   = r_owner ? wr_data_i[15:8] : wr_data_i[7:0];
      w_onehot  = r_owner ? 2'b10 : 2'b01;
      w_last    = (r_cnt + 4'd1 == r_len);
   end

   // r_gap marks the idle cycle between a completed command and the next one;
   // write pops land in this cycle so the byte is registered as the command issues.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_nxt       <= S_IDLE;
         r_gap       <= 1'b0;
         r_owner     <= 1'b0;
         r_ptr       <= 1'b0;
         r_rw        <= 1'b0;
         r_err       <= 1'b0;
         r_addr      <= '0;
         r_len       <= '0;
         r_cnt       <= '0;
         r_tmo       <= '0;
         r_ready     <= '0;
         r_pop       <= '0;
         r_rd_valid  <= '0;
         r_done      <= '0;
         r_rd_data   <= '0;
         r_cmd_data  <= '0;
         r_err_o     <= 1'b0;
         r_cmd_valid <= 1'b0;
         r_cmd       <= '0;
      end else begin
         r_ready    <= '0;
         r_pop      <= '0;
         r_rd_valid <= '0;
         r_done     <= '0;
         r_err_o    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|req_valid_i) begin
                  r_ready     <= w_win ? 2'b10 : 2'b01;
                  r_owner     <= w_win;
                  r_ptr       <= ~w_win;
                  r_addr      <= w_win ? req_addr_i[13:7] : req_addr_i[6:0];
                  r_rw        <= req_rw_i[w_win];
                  r_len       <= w_len;
                  r_cnt       <= '0;
                  r_err       <= 1'b0;
                  r_gap       <= 1'b0;
                  r_state     <= S_START;
                  r_cmd_valid <= 1'b1;
                  r_cmd       <= C_START;
                  r_cmd_data  <= '0;
                  r_tmo       <= TW'(TIMEOUT_CYCLES - 1);
               end
            end
            S_DONE: r_state <= S_IDLE;
            default: begin
               if (r_cmd_valid) begin
                  if (cmd_done_i) begin
                     r_cmd_valid <= 1'b0;
                     r_gap       <= 1'b1;
                     case (r_state)
                        S_START: r_nxt <= S_ADDR;
                        S_ADDR: begin
                           if (cmd_nak_i) begin
                              r_err <= 1'b1;
                              r_nxt <= S_STOP;
                           end else if (r_len == 4'd0) begin
                              r_nxt <= S_STOP;
                           end else begin
                              r_nxt <= S_DATA;
                              r_pop <= r_rw ? 2'b00 : w_onehot;
                           end
                        end
                        S_DATA: begin
                           r_cnt <= r_cnt + 4'd1;
                           if (r_rw) begin
                              r_rd_valid <= w_onehot;
                              r_rd_data  <= cmd_rdata_i;
                           end
                           if (!r_rw && cmd_nak_i) begin
                              r_err <= 1'b1;
                              r_nxt <= S_STOP;
                           end else if (w_last) begin
                              r_nxt <= S_STOP;
                           end else begin
                              r_nxt <= S_DATA;
                              r_pop <= r_rw ? 2'b00 : w_onehot;
                           end
                        end
                        default: r_nxt <= S_DONE;
                     endcase
                  end else if (r_tmo == '0) begin
                     r_cmd_valid <= 1'b0;
                     r_err       <= 1'b1;
                     r_state     <= S_DONE;
                     r_done      <= w_onehot;
                     r_err_o     <= 1'b1;
                  end else begin
                     r_tmo <= r_tmo - 1'b1;
                  end
               end else if (r_gap) begin
                  r_gap   <= 1'b0;
                  r_state <= r_nxt;
                  if (r_nxt == S_DONE) begin
                     r_done  <= w_onehot;
                     r_err_o <= r_err;
                  end else begin
                     r_cmd_valid <= 1'b1;
                     r_tmo       <= TW'(TIMEOUT_CYCLES - 1);
                     if (r_nxt == S_ADDR) begin
                        r_cmd      <= C_WRITE;
                        r_cmd_data <= {r_addr, r_rw};
                     end else if (r_nxt == S_STOP) begin
                        r_cmd      <= C_STOP;
                        r_cmd_data <= '0;
                     end else if (r_rw) begin
                        r_cmd      <= w_last ? C_READ_NAK : C_READ_ACK;
                        r_cmd_data <= '0;
                     end else begin
                        r_cmd      <= C_WRITE;
                        r_cmd_data <= w_wdata;
                     end
                  end
               end
            end
         endcase
      end
   end

   assign req_ready_o = r_ready;
   assign wr_pop_o    = r_pop;
   assign rd_data_o   = r_rd_data;
   assign rd_valid_o  = r_rd_valid;
   assign done_o      = r_done;
   assign err_o       = r_err_o;
   assign cmd_valid_o = r_cmd_valid;
   assign cmd_o       = r_cmd;
   assign cmd_data_o  = r_cmd_data;

endmodule

// File: tb/tb_i2c_xact_sequencer.sv
// Randomized bench for i2c_xact_sequencer: a responsive core model plus a transaction-level
// reference that predicts the command list, pops, reads, grant order and completion status.
module tb_i2c_xact_sequencer;

   localparam logic [2:0] C_READ_ACK = 3'b000;
   localparam logic [2:0] C_READ_NAK = 3'b001;
   localparam logic [2:0] C_START    = 3'b010;
   localparam logic [2:0] C_STOP     = 3'b011;
   localparam logic [2:0] C_WRITE    = 3'b100;
   localparam int         MAXL       = 8;
   localparam int         TMO        = 16;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [1:0]  req_valid_i;
   logic [13:0] req_addr_i;
   logic [1:0]  req_rw_i;
   logic [7:0]  req_len_i;
   logic [1:0]  req_ready_o;
   logic [15:0] wr_data_i;
   logic [1:0]  wr_pop_o;
   logic [7:0]  rd_data_o;
   logic [1:0]  rd_valid_o;
   logic [1:0]  done_o;
   logic        err_o;
   logic        cmd_valid_o;
   logic [2:0]  cmd_o;
   logic [7:0]  cmd_data_o;
   logic        cmd_done_i;
   logic        cmd_nak_i;
   logic [7:0]  cmd_rdata_i;

   always #5 clk_i = ~clk_i;

   i2c_xact_sequencer #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_rw_i(req_rw_i),
      .req_len_i(req_len_i), .req_ready_o(req_ready_o),
      .wr_data_i(wr_data_i), .wr_pop_o(wr_pop_o),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o),
      .done_o(done_o), .err_o(err_o),
      .cmd_valid_o(cmd_valid_o), .cmd_o(cmd_o), .cmd_data_o(cmd_data_o),
      .cmd_done_i(cmd_done_i), .cmd_nak_i(cmd_nak_i), .cmd_rdata_i(cmd_rdata_i)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // core model and observation state
   logic [10:0] obs_log[$];
   logic [10:0] exp_log[$];
   logic [7:0]  q_rd_exp[$];
   logic [7:0]  q_rd_obs[$];
   logic [7:0]  wr_bytes[2][16];
   int          wr_idx[2];
   int          pop_cnt[2];
   int          rd_cnt[2];
   int          cmd_idx, cur_idx, nak_idx, hi_len, wait_left;
   bit          seen, responded, just_done, mute;
   logic [1:0]  pop_prev;
   int          tb_ptr;
   int          exp_pops, exp_reads, exp_err;

   function automatic logic [31:0] outs_now();
      return {3'b000, req_ready_o, wr_pop_o, rd_data_o, rd_valid_o, done_o, err_o,
              cmd_valid_o, cmd_o, cmd_data_o};
   endfunction

   initial begin
      cmd_done_i = 1'b0; cmd_nak_i = 1'b0; cmd_rdata_i = '0; wr_data_i = '0;
      seen = 0; responded = 0; just_done = 0; wait_left = 0; pop_prev = '0;
      hi_len = 0; cur_idx = 0;
      forever begin
         @(posedge clk_i); #1;
         cmd_done_i = 1'b0;
         cmd_nak_i  = 1'b0;
         if (just_done) begin
            chk("cmd_valid_drop", {31'b0, cmd_valid_o}, 32'd0);
            just_done = 0;
         end
         for (int r = 0; r < 2; r++) begin
            if (pop_prev[r]) wr_idx[r]++;
            if (wr_pop_o[r]) pop_cnt[r]++;
            if (rd_valid_o[r]) rd_cnt[r]++;
         end
         pop_prev = wr_pop_o;
         if (rd_valid_o != 2'b00) q_rd_obs.push_back(rd_data_o);
         wr_data_i = {wr_bytes[1][wr_idx[1] % 16], wr_bytes[0][wr_idx[0] % 16]};
         if (!cmd_valid_o) begin
            seen = 0; responded = 0;
            wait_left = $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) begin
               cmd_done_i = 1'b1;
               cmd_nak_i  = 1'b1;
            end
         end else begin
            if (!seen) begin
               seen = 1;
               obs_log.push_back({cmd_o, cmd_data_o});
               cur_idx = cmd_idx;
               cmd_idx++;
               hi_len = 0;
            end
            hi_len++;
            if (!responded && !mute) begin
               if (wait_left == 0) begin
                  cmd_done_i = 1'b1;
                  cmd_nak_i  = (cur_idx == nak_idx);
                  if (cmd_o == C_READ_ACK || cmd_o == C_READ_NAK) begin
                     cmd_rdata_i = 8'($urandom);
                     q_rd_exp.push_back(cmd_rdata_i);
                  end
                  responded = 1;
                  just_done = 1;
               end else begin
                  wait_left--;
               end
            end
         end
      end
   end

   task automatic prep(input int nak, input bit m);
      obs_log.delete(); q_rd_exp.delete(); q_rd_obs.delete();
      for (int r = 0; r < 2; r++) begin
         pop_cnt[r] = 0; rd_cnt[r] = 0; wr_idx[r] = 0;
      end
      cmd_idx = 0; nak_idx = nak; mute = m;
   endtask

   // Transaction-level prediction: command list, pops, reads, error status.
   task automatic model(input int r, input int addr, input int rw, input int len,
                        input int nak, input bit m);
      int le;
      le = (len > MAXL) ? MAXL : len;
      exp_log.delete(); exp_pops = 0; exp_reads = 0; exp_err = 0;
      exp_log.push_back({C_START, 8'h00});
      if (m) begin exp_err = 1; return; end
      exp_log.push_back({C_WRITE, 7'(addr), 1'(rw)});
      if (nak == 1) begin
         exp_err = 1;
         exp_log.push_back({C_STOP, 8'h00});
         return;
      end
      for (int k = 0; k < le; k++) begin
         if (rw != 0) begin
            exp_log.push_back({(k == le - 1) ? C_READ_NAK : C_READ_ACK, 8'h00});
            exp_reads++;
         end else begin
            exp_log.push_back({C_WRITE, wr_bytes[r][k]});
            exp_pops++;
            if (nak == 2 + k) begin exp_err = 1; break; end
         end
      end
      exp_log.push_back({C_STOP, 8'h00});
   endtask

   task automatic wait_grant(input logic [1:0] exp);
      int n = 0;
      while (req_ready_o == 2'b00 && n < 100) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("grant", {30'b0, req_ready_o}, {30'b0, exp});
   endtask

   task automatic wait_done(input logic [1:0] exp, input int e);
      int n = 0;
      while (done_o == 2'b00 && n < 3000) begin
         @(posedge clk_i); #1;
         n++;
      end
      chk("done", {30'b0, done_o}, {30'b0, exp});
      chk("err", {31'b0, err_o}, 32'(e));
   endtask

   task automatic request(input int r, input int addr, input int rw, input int len);
      req_addr_i[7*r +: 7] = 7'(addr);
      req_rw_i[r]          = 1'(rw);
      req_len_i[4*r +: 4]  = 4'(len);
      req_valid_i[r]       = 1'b1;
      wait_grant(2'b01 << r);
      req_valid_i[r]       = 1'b0;
      tb_ptr               = 1 - r;
      req_addr_i[7*r +: 7] = 7'($urandom);
      req_rw_i[r]          = 1'($urandom);
      req_len_i[4*r +: 4]  = 4'($urandom);
   endtask

   task automatic run_xact(input int r, input int addr, input int rw, input int len,
                           input int nak, input bit m);
      int n;
      prep(nak, m);
      model(r, addr, rw, len, nak, m);
      request(r, addr, rw, len);
      wait_done(2'b01 << r, exp_err);
      chk("ncmd", 32'(obs_log.size()), 32'(exp_log.size()));
      n = (obs_log.size() < exp_log.size()) ? obs_log.size() : exp_log.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("cmd%0d", i), {29'b0, obs_log[i][10:8]}, {29'b0, exp_log[i][10:8]});
         if (exp_log[i][10:8] == C_WRITE)
            chk($sformatf("cdata%0d", i), {24'b0, obs_log[i][7:0]}, {24'b0, exp_log[i][7:0]});
      end
      chk("pops", 32'(pop_cnt[r]), 32'(exp_pops));
      chk("pops_other", 32'(pop_cnt[1-r]), 32'd0);
      chk("reads", 32'(rd_cnt[r]), 32'(exp_reads));
      chk("reads_other", 32'(rd_cnt[1-r]), 32'd0);
      chk("nrd", 32'(q_rd_obs.size()), 32'(q_rd_exp.size()));
      for (int i = 0; i < q_rd_obs.size() && i < q_rd_exp.size(); i++)
         chk($sformatf("rdata%0d", i), {24'b0, q_rd_obs[i]}, {24'b0, q_rd_exp[i]});
      @(posedge clk_i); #1;
   endtask

   task automatic arb_pair();
      int w;
      prep(-1, 0);
      req_len_i   = '0;
      req_rw_i    = '0;
      req_addr_i  = 14'($urandom);
      req_valid_i = 2'b11;
      for (int k = 0; k < 2; k++) begin
         w = (req_valid_i == 2'b11) ? tb_ptr : (req_valid_i[1] ? 1 : 0);
         wait_grant(2'b01 << w);
         req_valid_i[w] = 1'b0;
         tb_ptr = 1 - w;
         wait_done(2'b01 << w, 0);
      end
      @(posedge clk_i); #1;
   endtask

   initial begin
      int r, rw, len, le, nak, dn;
      rst_i = 1'b1; req_valid_i = '0; req_addr_i = '0; req_rw_i = '0; req_len_i = '0;
      mute = 0; nak_idx = -1; tb_ptr = 0; cmd_idx = 0;
      for (int i = 0; i < 2; i++) for (int j = 0; j < 16; j++) wr_bytes[i][j] = 8'($urandom);
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_outs", outs_now(), 32'd0);
      rst_i = 1'b0;
      @(posedge clk_i); #1;

      wr_bytes[0][0] = 8'hA5; wr_bytes[0][1] = 8'h5A;
      run_xact(0, 7'h44, 0, 2, -1, 0);
      run_xact(1, 7'h44, 1, 3, -1, 0);
      run_xact(0, 7'h44, 0, 4, 1, 0);
      arb_pair();
      arb_pair();

      for (int t = 0; t < 24; t++) begin
         r   = $urandom_range(0, 1);
         rw  = $urandom_range(0, 1);
         len = $urandom_range(0, 15);
         le  = (len > MAXL) ? MAXL : len;
         for (int j = 0; j < 16; j++) wr_bytes[r][j] = 8'($urandom);
         case ($urandom_range(0, 3))
            0: nak = 1;
            1: nak = (rw == 0 && le > 0) ? 2 + $urandom_range(0, le - 1) : -1;
            default: nak = -1;
         endcase
         run_xact(r, $urandom_range(0, 127), rw, len, nak, 0);
      end

      run_xact(0, 7'h21, 0, 2, -1, 1);
      chk("tmo_len", 32'(hi_len), 32'(TMO));
      mute = 0;

      // reset in the middle of a write data phase from requester 0
      prep(-1, 0);
      for (int j = 0; j < 16; j++) wr_bytes[0][j] = 8'($urandom);
      request(0, 7'h33, 0, 4);
      for (int n = 0; n < 300 && obs_log.size() < 3; n++) begin
         @(posedge clk_i); #1;
      end
      chk("reached_data", 32'(obs_log.size() >= 3), 32'd1);
      rst_i = 1'b1;
      @(posedge clk_i); #1;
      chk("rst_mid_outs", outs_now(), 32'd0);
      rst_i = 1'b0;
      tb_ptr = 0;
      dn = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk_i); #1;
         if (done_o != 2'b00) dn++;
      end
      chk("no_done_after_rst", 32'(dn), 32'd0);
      arb_pair();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/i2c_xact_sequencer.md
I2C_XACT_SEQUENCER -- requirements
Module: i2c_xact_sequencer

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 8: largest data-byte count per transaction (1..15).
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: clk_i cycles allowed per byte-level command before abort.
REQ-003 Port clk_i SHALL be: input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-004 Port rst_i SHALL be: input, 1 bit, synchronous active-high reset.
REQ-005 Port req_valid_i SHALL be: input, 2 bits, per-requester transaction request, held until accepted.
REQ-006 Port req_addr_i SHALL be: input, 14 bits, 7-bit slave address per requester, with requester 1 in [13:7].
REQ-007 Port req_rw_i SHALL be: input, 2 bits, per-requester direction: 1 = read, 0 = write.
REQ-008 Port req_len_i SHALL be: input, 8 bits, 4-bit data-byte count per requester; 0 = address-only probe.
REQ-009 Port req_ready_o SHALL be: output, 2 bits, one-hot single-cycle accept pulse.
REQ-010 Port wr_data_i SHALL be: input, 16 bits, next write byte per requester, with requester 1 in [15:8].
REQ-011 Port wr_pop_o SHALL be: output, 2 bits, one-hot pulse that consumes the current wr_data_i byte.
REQ-012 Port rd_data_o SHALL be: output, 8 bits, received byte.
REQ-013 Port rd_valid_o SHALL be: output, 2 bits, one-hot pulse qualifying rd_data_o for the owning requester.
REQ-014 Port done_o SHALL be: output, 2 bits, one-hot transaction-complete pulse.
REQ-015 Port err_o SHALL be: output, 1 bit, valid only with done_o; 1 = NAK or timeout.
REQ-016 Port cmd_valid_o SHALL be: output, 1 bit, command request to the byte-level I2C master core.
REQ-017 Port cmd_o SHALL be: output, 3 bits, command code: 000 READ_ACK, 001 READ_NAK, 010 START, 011 STOP, 100 WRITE.
REQ-018 Port cmd_data_o SHALL be: output, 8 bits, byte for the WRITE command.
REQ-019 Port cmd_done_i SHALL be: input, 1 bit, single-cycle completion pulse from the core.
REQ-020 Port cmd_nak_i SHALL be: input, 1 bit, NAK status, valid with cmd_done_i on WRITE.
REQ-021 Port cmd_rdata_i SHALL be: input, 8 bits, read byte, valid with cmd_done_i on READ_*.

Function
REQ-022 The FSM SHALL have states IDLE, START, ADDR, DATA, STOP, DONE.
REQ-023 In IDLE with any req_valid_i set, the block SHALL pulse req_ready_o for the winner in the next cycle, latch its addr/rw/len (len clamped to MAX_LEN), and enter START.
REQ-024 Arbitration SHALL be round-robin: on simultaneous requests the requester not most recently granted wins, and requester 0 wins first after reset.
REQ-025 cmd_valid_o SHALL assert in the first cycle of START, ADDR, DATA and STOP, hold with stable cmd_o/cmd_data_o until cmd_done_i, and deassert in the cycle after cmd_done_i.
REQ-026 After START completes, ADDR SHALL issue WRITE with cmd_data_o = {addr, rw}.
REQ-027 A NAK on ADDR or on any write-data byte SHALL set the error flag, skip the remaining bytes, and go to STOP.
REQ-028 In write DATA, the block SHALL pulse wr_pop_o one cycle before each WRITE cmd_valid_o, registering wr_data_i on the pop cycle.
REQ-029 In read DATA, the block SHALL issue READ_ACK for bytes 1..len-1 and READ_NAK for byte len, and pulse rd_valid_o with rd_data_o = cmd_rdata_i in the cycle after each cmd_done_i.
REQ-030 When len = 0, the block SHALL go from ADDR directly to STOP.
REQ-031 A per-command counter SHALL reset on every new cmd_valid_o; reaching TIMEOUT_CYCLES without cmd_done_i SHALL drop cmd_valid_o, set the error flag, and go to DONE without issuing STOP.
REQ-032 DONE SHALL last 1 cycle: it pulses done_o for the owner with err_o, then returns to IDLE, and a new grant is possible in the following cycle.
REQ-033 A cmd_done_i that arrives while cmd_valid_o is low SHALL be ignored.
REQ-034 Changes on req_* inputs after acceptance SHALL have no effect on the transaction in progress.

Reset
REQ-035 On rst_i, the block SHALL go to IDLE within one edge, with all outputs at 0, the round-robin pointer pointing to requester 0, and the counters at 0.
REQ-036 A reset during a transaction SHALL abandon it immediately with no STOP, done_o or err_o.

Verification
REQ-037 Requester 0 writes 2 bytes (addr 0x44, A5, 5A), all ACK -> cmd sequence START, WRITE 0x88, WRITE A5, WRITE 5A, STOP; two wr_pop_o[0] pulses; done_o=01, err_o=0.
REQ-038 Requester 1 reads 3 bytes (addr 0x44) -> START, WRITE 0x89, READ_ACK, READ_ACK, READ_NAK, STOP; three rd_valid_o=10 pulses carrying the core bytes; done_o=10.
REQ-039 Both requesters valid in the same cycle twice in a row -> grants 0 then 1; after the second transaction completes, requester 0 is granted next.
REQ-040 Address NAK with len=4 -> START, WRITE addr, STOP only; no wr_pop_o; done_o with err_o=1.
REQ-041 TIMEOUT_CYCLES=16 with the core never answering START -> cmd_valid_o drops after 16 cycles; done_o with err_o=1; no STOP issued.
REQ-042 rst_i asserted mid-DATA -> next cycle all outputs 0, no done_o pulse, and a fresh request afterwards is granted to requester 0.
